// File: rtl/ad7606_pkg.sv
// ad7606_pkg
//  Shared definitions for the AD7606 conversion sequencer:
//  - seq_state_e : sequencer FSM state encoding
//  - DEF_*       : default timing / geometry constants
//  - sticky_next : next value of a sticky flag (set wins over clear)
package ad7606_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // waiting for a rate tick
    ST_CONV = 3'd1,  // CONVST held low
    ST_WBH  = 3'd2,  // waiting for BUSY to rise
    ST_WBL  = 3'd3,  // waiting for BUSY to fall
    ST_RDL  = 3'd4,  // RD low phase of one word
    ST_RDH  = 3'd5   // RD high phase between words
  } seq_state_e;

  localparam int DEF_CHANNELS     = 8;
  localparam int DEF_DW           = 16;
  localparam int DEF_PER_W        = 16;
  localparam int DEF_CONV_PULSE   = 5;
  localparam int DEF_RD_LOW       = 4;
  localparam int DEF_RD_HIGH      = 3;
  localparam int DEF_BUSY_TIMEOUT = 1000;

  // A set request in the same cycle as a clear keeps the flag at 1.
  function automatic logic sticky_next(input logic q, input logic set, input logic clr);
    return set | (q & ~clr);
  endfunction

endpackage

// File: rtl/ad7606_rate_gen.sv
// ad7606_rate_gen
//  Sample-period pacer for the AD7606 sequencer.
//  Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   en_i             : run enable; while low the counter is held at zero
//   period_i         : period in clk_i cycles, reloaded at every tick; 0 acts as 1
//   idle_i           : sequencer is in IDLE
//   tick_o           : start-of-period pulse (combinational from the counter)
//   overrun_o        : tick landed while a frame was running (set request)
module ad7606_rate_gen
  import ad7606_pkg::*;
#(
  parameter int PER_W = DEF_PER_W
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             en_i,
  input  logic [PER_W-1:0] period_i,
  input  logic             idle_i,
  output logic             tick_o,
  output logic             overrun_o
);

  logic [PER_W-1:0] cnt_q;
  logic [PER_W-1:0] cnt_d;

  // A zeroed counter ticks on the first enabled cycle, so enabling starts a frame at once.
  assign tick_o = en_i & (cnt_q == {PER_W{1'b0}});

  // Back-to-back mode (period 0) ticks every cycle by design, so it never reports overrun.
  assign overrun_o = tick_o & ~idle_i & (period_i != {PER_W{1'b0}});

  // Down-counter: reload period-1 on a tick, clear while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = {PER_W{1'b0}};
    end else if (cnt_q == {PER_W{1'b0}}) begin
      if (period_i == {PER_W{1'b0}}) begin
        cnt_d = {PER_W{1'b0}};
      end else begin
        cnt_d = period_i - {{(PER_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q - {{(PER_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= {PER_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ad7606_seq_ctrl.sv
// ad7606_seq_ctrl
//  Conversion sequencer for one AD7606: paces conversions, walks the ADC
//  through CONVST -> BUSY -> CS/RD, pushes CHANNELS words per frame into the
//  DAQ FIFO and keeps sticky error flags.
//  Ports:
//   clk_i, reset_n_i          : clock, asynchronous active-low reset
//   en_i, period_i, clr_i     : run enable, sample period, sticky-flag clear
//   busy_i, frstdata_i, db_i  : ADC status (asynchronous) and parallel data
//   convst_o, cs_n_o, rd_n_o  : ADC control strobes (registered)
//   fifo_full_i, fifo_wrreq_o, fifo_data_o : FIFO write side
//   idle_o, frame_count_o     : status
//   overflow_o, timeout_o, overrun_o, frame_err_o : sticky error flags
module ad7606_seq_ctrl
  import ad7606_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int DW           = DEF_DW,
  parameter int PER_W        = DEF_PER_W,
  parameter int CONV_PULSE   = DEF_CONV_PULSE,
  parameter int RD_LOW       = DEF_RD_LOW,
  parameter int RD_HIGH      = DEF_RD_HIGH,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             en_i,
  input  logic [PER_W-1:0] period_i,
  input  logic             clr_i,
  input  logic             busy_i,
  input  logic             frstdata_i,
  input  logic [DW-1:0]    db_i,
  output logic             convst_o,
  output logic             cs_n_o,
  output logic             rd_n_o,
  input  logic             fifo_full_i,
  output logic             fifo_wrreq_o,
  output logic [DW-1:0]    fifo_data_o,
  output logic             idle_o,
  output logic [PER_W-1:0] frame_count_o,
  output logic             overflow_o,
  output logic             timeout_o,
  output logic             overrun_o,
  output logic             frame_err_o
);

  localparam int MAX_A   = (BUSY_TIMEOUT > CONV_PULSE) ? BUSY_TIMEOUT : CONV_PULSE;
  localparam int MAX_B   = (RD_LOW > RD_HIGH) ? RD_LOW : RD_HIGH;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int CH_W    = $clog2(CHANNELS + 1);

  logic [1:0]       busy_sync_q;
  logic [1:0]       frst_sync_q;
  logic             tick_s;
  logic             overrun_set_s;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             drop_q, drop_d;
  logic             convst_q, convst_d;
  logic             cs_n_q, cs_n_d;
  logic             rd_n_q, rd_n_d;
  logic             wrreq_q, wrreq_d;
  logic [DW-1:0]    data_q, data_d;
  logic             idle_q, idle_d;
  logic [PER_W-1:0] count_q, count_d;
  logic             overflow_q, timeout_q, overrun_q, frame_err_q;
  logic             ovf_set_s, tmo_set_s, ferr_set_s;

  ad7606_rate_gen #(
    .PER_W(PER_W)
  ) u_rate_gen (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (en_i),
    .period_i  (period_i),
    .idle_i    (state_q == ST_IDLE),
    .tick_o    (tick_s),
    .overrun_o (overrun_set_s)
  );

  // Two-flop synchronisers for the asynchronous ADC status lines.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_sync_q <= 2'b00;
      frst_sync_q <= 2'b00;
    end else begin
      busy_sync_q <= {busy_sync_q[0], busy_i};
      frst_sync_q <= {frst_sync_q[0], frstdata_i};
    end
  end

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    drop_d     = drop_q;
    convst_d   = convst_q;
    cs_n_d     = cs_n_q;
    rd_n_d     = rd_n_q;
    wrreq_d    = 1'b0;
    data_d     = data_q;
    count_d    = count_q;
    ovf_set_s  = 1'b0;
    tmo_set_s  = 1'b0;
    ferr_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_s) begin
          state_d  = ST_CONV;
          convst_d = 1'b0;
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (cnt_q == CNT_W'(CONV_PULSE - 1)) begin
          state_d  = ST_WBH;
          convst_d = 1'b1;
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      ST_WBH: begin
        if (busy_sync_q[1]) begin
          state_d   = ST_WBL;
          cnt_d     = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          tmo_set_s = 1'b1;
          cnt_d     = {CNT_W{1'b0}};
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      ST_WBL: begin
        if (!busy_sync_q[1]) begin
          // FIFO state is judged once per frame so a frame is all-or-nothing.
          state_d   = ST_RDL;
          cs_n_d    = 1'b0;
          rd_n_d    = 1'b0;
          ch_d      = {CH_W{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
          drop_d    = fifo_full_i;
          ovf_set_s = fifo_full_i;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          cs_n_d    = 1'b1;
          tmo_set_s = 1'b1;
          cnt_d     = {CNT_W{1'b0}};
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      ST_RDL: begin
        if (cnt_q == CNT_W'(RD_LOW - 1)) begin
          state_d = ST_RDH;
          rd_n_d  = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          data_d  = db_i;
          wrreq_d = ~drop_q;
          if (ch_q == {CH_W{1'b0}}) begin
            ferr_set_s = ~frst_sync_q[1];
          end else begin
            ferr_set_s = 1'b0;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_RDH: begin
        if (cnt_q == CNT_W'(RD_HIGH - 1)) begin
          cnt_d = {CNT_W{1'b0}};
          if (ch_q == CH_W'(CHANNELS - 1)) begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
            count_d = count_q + PER_W'(1);
          end else begin
            state_d = ST_RDL;
            rd_n_d  = 1'b0;
            ch_d    = ch_q + CH_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        convst_d = 1'b1;
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        cnt_d    = {CNT_W{1'b0}};
      end
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  // Sequencer state, registered outputs and sticky flags.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      ch_q        <= {CH_W{1'b0}};
      drop_q      <= 1'b0;
      convst_q    <= 1'b1;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wrreq_q     <= 1'b0;
      data_q      <= {DW{1'b0}};
      idle_q      <= 1'b1;
      count_q     <= {PER_W{1'b0}};
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      drop_q      <= drop_d;
      convst_q    <= convst_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wrreq_q     <= wrreq_d;
      data_q      <= data_d;
      idle_q      <= idle_d;
      count_q     <= count_d;
      overflow_q  <= sticky_next(overflow_q, ovf_set_s, clr_i);
      timeout_q   <= sticky_next(timeout_q, tmo_set_s, clr_i);
      overrun_q   <= sticky_next(overrun_q, overrun_set_s, clr_i);
      frame_err_q <= sticky_next(frame_err_q, ferr_set_s, clr_i);
    end
  end

  assign convst_o      = convst_q;
  assign cs_n_o        = cs_n_q;
  assign rd_n_o        = rd_n_q;
  assign fifo_wrreq_o  = wrreq_q;
  assign fifo_data_o   = data_q;
  assign idle_o        = idle_q;
  assign frame_count_o = count_q;
  assign overflow_o    = overflow_q;
  assign timeout_o     = timeout_q;
  assign overrun_o     = overrun_q;
  assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_ad7606_seq_ctrl.sv
// tb_ad7606_seq_ctrl
//  Directed bench for ad7606_seq_ctrl with a behavioural AD7606 model:
//  BUSY pulses busy_len cycles after each CONVST rise, db_i = 0x1000 + word
//  index within the frame, FRSTDATA high on word 0 unless forced low.
module tb_ad7606_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        en_i = 1'b0;
  logic [15:0] period_i = 16'd0;
  logic        clr_i = 1'b0;
  logic        busy_i = 1'b0;
  logic        frstdata_i = 1'b0;
  logic [15:0] db_i = 16'd0;
  logic        fifo_full_i = 1'b0;
  logic        convst_o, cs_n_o, rd_n_o, fifo_wrreq_o, idle_o;
  logic [15:0] fifo_data_o, frame_count_o;
  logic        overflow_o, timeout_o, overrun_o, frame_err_o;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // ADC model controls and monitor state
  int   busy_len = 100;
  bit   busy_stuck = 1'b0;
  bit   frst_force0 = 1'b0;
  int   busy_cnt = 0;
  int   word_idx = 0;
  logic convst_prev = 1'b1, rd_prev = 1'b1, cs_prev = 1'b1;
  int   wr_cnt = 0, rd_cnt = 0, cs_low_cnt = 0;
  int   conv_rise_cyc = 0, rd_fall_cyc = 0, rd_rise_cyc = 0;
  int   rd_low_w = 0, rd_high_w = 0;
  int   conv_fall_q[$];
  logic [15:0] log_mem [0:1023];

  ad7606_seq_ctrl #(
    .CHANNELS(8), .DW(16), .PER_W(16), .CONV_PULSE(5),
    .RD_LOW(4), .RD_HIGH(3), .BUSY_TIMEOUT(1000)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .en_i(en_i), .period_i(period_i),
    .clr_i(clr_i), .busy_i(busy_i), .frstdata_i(frstdata_i), .db_i(db_i),
    .convst_o(convst_o), .cs_n_o(cs_n_o), .rd_n_o(rd_n_o),
    .fifo_full_i(fifo_full_i), .fifo_wrreq_o(fifo_wrreq_o), .fifo_data_o(fifo_data_o),
    .idle_o(idle_o), .frame_count_o(frame_count_o), .overflow_o(overflow_o),
    .timeout_o(timeout_o), .overrun_o(overrun_o), .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ADC model and bus monitor, evaluated away from the active edge
  always @(negedge clk) begin
    if (convst_o && !convst_prev) begin
      conv_rise_cyc = cyc;
      if (!busy_stuck) busy_cnt = busy_len;
    end
    if (!convst_o && convst_prev) conv_fall_q.push_back(cyc);
    convst_prev = convst_o;
    if (busy_cnt > 0) begin
      busy_i = 1'b1;
      busy_cnt = busy_cnt - 1;
    end else begin
      busy_i = 1'b0;
    end
    if (!rd_n_o && rd_prev) begin
      rd_cnt++;
      if (!cs_prev) rd_high_w = cyc - rd_rise_cyc;
      rd_fall_cyc = cyc;
    end
    if (rd_n_o && !rd_prev) begin
      word_idx++;
      rd_low_w = cyc - rd_fall_cyc;
      rd_rise_cyc = cyc;
    end
    if (cs_n_o) word_idx = 0;
    else cs_low_cnt++;
    rd_prev = rd_n_o;
    cs_prev = cs_n_o;
    db_i = 16'h1000 + 16'(word_idx);
    frstdata_i = (word_idx == 0) && !frst_force0;
    if (fifo_wrreq_o) begin
      if (wr_cnt < 1024) log_mem[wr_cnt] = fifo_data_o;
      wr_cnt++;
    end
  end

  task automatic pulse_clr();
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
  endtask

  task automatic stop_run();
    en_i = 1'b0;
    for (int i = 0; i < 2000 && idle_o !== 1'b1; i++) @(negedge clk);
    checks++; if (idle_o !== 1'b1) $display("FAIL stop_idle: got %b expected 1", idle_o); else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (convst_o !== 1'b1) $display("FAIL rst_convst: got %b expected 1", convst_o); else passed++;
    checks++; if (cs_n_o !== 1'b1) $display("FAIL rst_cs_n: got %b expected 1", cs_n_o); else passed++;
    checks++; if (rd_n_o !== 1'b1) $display("FAIL rst_rd_n: got %b expected 1", rd_n_o); else passed++;
    checks++; if (fifo_wrreq_o !== 1'b0) $display("FAIL rst_wrreq: got %b expected 0", fifo_wrreq_o); else passed++;
    checks++; if (fifo_data_o !== 16'h0000) $display("FAIL rst_data: got %h expected 0000", fifo_data_o); else passed++;
    checks++; if (idle_o !== 1'b1) $display("FAIL rst_idle: got %b expected 1", idle_o); else passed++;
    checks++; if (frame_count_o !== 16'd0) $display("FAIL rst_count: got %0d expected 0", frame_count_o); else passed++;
    checks++; if ({overflow_o, timeout_o, overrun_o, frame_err_o} !== 4'b0000)
      $display("FAIL rst_flags: got %b expected 0000", {overflow_o, timeout_o, overrun_o, frame_err_o}); else passed++;
  endtask

  task automatic test_normal();
    int w0, r0, q0;
    logic [15:0] f0;
    period_i = 16'd400; busy_len = 100;
    w0 = wr_cnt; r0 = rd_cnt; q0 = conv_fall_q.size(); f0 = frame_count_o;
    en_i = 1'b1;
    for (int i = 0; i < 3000 && frame_count_o !== f0 + 16'd2; i++) @(negedge clk);
    en_i = 1'b0;
    checks++; if (frame_count_o !== f0 + 16'd2) $display("FAIL norm_frames: got %0d expected %0d", frame_count_o, f0 + 16'd2); else passed++;
    checks++; if (wr_cnt - w0 !== 16) $display("FAIL norm_wrreqs: got %0d expected 16", wr_cnt - w0); else passed++;
    checks++; if (rd_cnt - r0 !== 16) $display("FAIL norm_rd_pulses: got %0d expected 16", rd_cnt - r0); else passed++;
    for (int k = 0; k < 16; k++) begin
      checks++; if (log_mem[w0 + k] !== 16'h1000 + 16'(k % 8))
        $display("FAIL norm_data[%0d]: got %h expected %h", k, log_mem[w0 + k], 16'h1000 + 16'(k % 8)); else passed++;
    end
    checks++; if (conv_fall_q.size() < q0 + 2) $display("FAIL norm_conv_count: got %0d expected %0d", conv_fall_q.size() - q0, 2);
    else begin
      passed++;
      checks++; if (conv_fall_q[q0 + 1] - conv_fall_q[q0] !== 400)
        $display("FAIL norm_period: got %0d expected 400", conv_fall_q[q0 + 1] - conv_fall_q[q0]); else passed++;
      checks++; if (conv_rise_cyc - conv_fall_q[q0 + 1] !== 5)
        $display("FAIL norm_convst_width: got %0d expected 5", conv_rise_cyc - conv_fall_q[q0 + 1]); else passed++;
    end
    checks++; if (rd_low_w !== 4) $display("FAIL norm_rd_low: got %0d expected 4", rd_low_w); else passed++;
    checks++; if (rd_high_w !== 3) $display("FAIL norm_rd_high: got %0d expected 3", rd_high_w); else passed++;
    checks++; if ({overrun_o, frame_err_o, overflow_o, timeout_o} !== 4'b0000)
      $display("FAIL norm_flags: got %b expected 0000", {overrun_o, frame_err_o, overflow_o, timeout_o}); else passed++;
    stop_run();
  endtask

  task automatic test_timeout();
    int w0, c0, dt;
    logic [15:0] f0;
    busy_stuck = 1'b1; period_i = 16'd3000;
    w0 = wr_cnt; c0 = cs_low_cnt; f0 = frame_count_o;
    en_i = 1'b1;
    for (int i = 0; i < 1500 && timeout_o !== 1'b1; i++) @(negedge clk);
    dt = cyc - conv_rise_cyc;
    en_i = 1'b0;
    checks++; if (timeout_o !== 1'b1) $display("FAIL tmo_flag: got %b expected 1", timeout_o); else passed++;
    checks++; if (dt !== 1000) $display("FAIL tmo_latency: got %0d expected 1000", dt); else passed++;
    @(negedge clk);
    checks++; if (idle_o !== 1'b1) $display("FAIL tmo_idle: got %b expected 1", idle_o); else passed++;
    checks++; if (cs_low_cnt !== c0) $display("FAIL tmo_cs: got %0d cs-low cycles expected 0", cs_low_cnt - c0); else passed++;
    checks++; if (wr_cnt !== w0) $display("FAIL tmo_wrreq: got %0d expected 0", wr_cnt - w0); else passed++;
    checks++; if (frame_count_o !== f0) $display("FAIL tmo_count: got %0d expected %0d", frame_count_o, f0); else passed++;
    pulse_clr();
    checks++; if (timeout_o !== 1'b0) $display("FAIL tmo_clr: got %b expected 0", timeout_o); else passed++;
    busy_stuck = 1'b0;
    stop_run();
  endtask

  task automatic test_overflow();
    int w0, r0;
    logic [15:0] f0;
    fifo_full_i = 1'b1; period_i = 16'd3000; busy_len = 100;
    w0 = wr_cnt; r0 = rd_cnt; f0 = frame_count_o;
    en_i = 1'b1;
    for (int i = 0; i < 1500 && frame_count_o !== f0 + 16'd1; i++) @(negedge clk);
    en_i = 1'b0; fifo_full_i = 1'b0;
    checks++; if (frame_count_o !== f0 + 16'd1) $display("FAIL ovf_count: got %0d expected %0d", frame_count_o, f0 + 16'd1); else passed++;
    checks++; if (rd_cnt - r0 !== 8) $display("FAIL ovf_rd_pulses: got %0d expected 8", rd_cnt - r0); else passed++;
    checks++; if (wr_cnt !== w0) $display("FAIL ovf_wrreq: got %0d expected 0", wr_cnt - w0); else passed++;
    checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow_o); else passed++;
    pulse_clr();
    checks++; if (overflow_o !== 1'b0) $display("FAIL ovf_clr: got %b expected 0", overflow_o); else passed++;
    stop_run();
  endtask

  task automatic test_overrun();
    int w0, nf;
    logic [15:0] f0;
    period_i = 16'd50; busy_len = 400;
    w0 = wr_cnt; f0 = frame_count_o;
    en_i = 1'b1;
    for (int i = 0; i < 3000 && frame_count_o !== f0 + 16'd2; i++) @(negedge clk);
    checks++; if (overrun_o !== 1'b1) $display("FAIL orun_flag: got %b expected 1", overrun_o); else passed++;
    stop_run();
    nf = int'(frame_count_o - f0);
    checks++; if (nf < 2) $display("FAIL orun_frames: got %0d expected >=2", nf); else passed++;
    checks++; if (wr_cnt - w0 !== 8 * nf) $display("FAIL orun_whole_frames: got %0d words expected %0d", wr_cnt - w0, 8 * nf); else passed++;
    for (int k = 0; k < 16; k++) begin
      checks++; if (log_mem[w0 + k] !== 16'h1000 + 16'(k % 8))
        $display("FAIL orun_data[%0d]: got %h expected %h", k, log_mem[w0 + k], 16'h1000 + 16'(k % 8)); else passed++;
    end
    pulse_clr();
    checks++; if (overrun_o !== 1'b0) $display("FAIL orun_clr: got %b expected 0", overrun_o); else passed++;
    busy_len = 100;
  endtask

  task automatic test_frame_err();
    int w0;
    logic [15:0] f0;
    frst_force0 = 1'b1; period_i = 16'd3000;
    w0 = wr_cnt; f0 = frame_count_o;
    en_i = 1'b1;
    for (int i = 0; i < 1500 && frame_count_o !== f0 + 16'd1; i++) @(negedge clk);
    en_i = 1'b0;
    checks++; if (frame_err_o !== 1'b1) $display("FAIL ferr_flag: got %b expected 1", frame_err_o); else passed++;
    checks++; if (wr_cnt - w0 !== 8) $display("FAIL ferr_wrreq: got %0d expected 8", wr_cnt - w0); else passed++;
    checks++; if (log_mem[w0] !== 16'h1000) $display("FAIL ferr_data0: got %h expected 1000", log_mem[w0]); else passed++;
    checks++; if (log_mem[w0 + 7] !== 16'h1007) $display("FAIL ferr_data7: got %h expected 1007", log_mem[w0 + 7]); else passed++;
    frst_force0 = 1'b0;
    pulse_clr();
    checks++; if (frame_err_o !== 1'b0) $display("FAIL ferr_clr: got %b expected 0", frame_err_o); else passed++;
    stop_run();
  endtask

  task automatic test_back_to_back();
    int w0, nf;
    logic [15:0] f0;
    period_i = 16'd0; busy_len = 100;
    w0 = wr_cnt; f0 = frame_count_o;
    en_i = 1'b1;
    for (int i = 0; i < 2000 && frame_count_o !== f0 + 16'd3; i++) @(negedge clk);
    stop_run();
    nf = int'(frame_count_o - f0);
    checks++; if (nf < 3) $display("FAIL b2b_frames: got %0d expected >=3", nf); else passed++;
    checks++; if (wr_cnt - w0 !== 8 * nf) $display("FAIL b2b_words: got %0d expected %0d", wr_cnt - w0, 8 * nf); else passed++;
    checks++; if (overrun_o !== 1'b0) $display("FAIL b2b_overrun: got %b expected 0", overrun_o); else passed++;
  endtask

  task automatic test_reset_mid();
    int w0;
    period_i = 16'd3000;
    en_i = 1'b1;
    for (int i = 0; i < 1500 && !(word_idx == 3 && rd_n_o === 1'b0); i++) @(negedge clk);
    checks++; if (!(word_idx == 3 && rd_n_o === 1'b0)) $display("FAIL rmid_reach: got word %0d rd_n %b expected word 3 rd_n 0", word_idx, rd_n_o); else passed++;
    reset_n_i = 1'b0;
    #1;
    w0 = wr_cnt;
    checks++; if ({convst_o, cs_n_o, rd_n_o} !== 3'b111) $display("FAIL rmid_strobes: got %b expected 111", {convst_o, cs_n_o, rd_n_o}); else passed++;
    checks++; if (idle_o !== 1'b1) $display("FAIL rmid_idle: got %b expected 1", idle_o); else passed++;
    checks++; if (fifo_wrreq_o !== 1'b0) $display("FAIL rmid_wrreq: got %b expected 0", fifo_wrreq_o); else passed++;
    en_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_n_i = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (wr_cnt !== w0) $display("FAIL rmid_no_write: got %0d extra writes expected 0", wr_cnt - w0); else passed++;
    checks++; if (frame_count_o !== 16'd0) $display("FAIL rmid_count: got %0d expected 0", frame_count_o); else passed++;
  endtask

  initial begin
    #1 reset_n_i = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk);
    test_normal();
    test_timeout();
    test_overflow();
    test_overrun();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
